// File: rtl/bounce_gen_pkg.sv
// rtl/bounce_gen_pkg.sv - shared encodings and LFSR constants for bounce_generator
package bounce_gen_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } bounce_state_t;

  localparam int          LFSR_W        = 16;
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  // An all-zero Fibonacci LFSR locks up, so a zero seed is swapped out.
  function automatic logic [LFSR_W-1:0] lfsr_fix_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? LFSR_ZERO_SUB : seed;
  endfunction

  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr.sv
// rtl/bounce_gen_lfsr.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every non-reset cycle
module bounce_gen_lfsr
  import bounce_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic feedback;

  assign feedback = ^(state & LFSR_TAP_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= lfsr_fix_seed(seed);
    end else begin
      state <= {state[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/bounce_generator.sv
// rtl/bounce_generator.sv - per-channel contact-bounce emulator; BOUNCE_GEN_LFSR_EN selects random toggling
module bounce_generator
  import bounce_gen_pkg::*;
#(
  parameter int          WIDTH         = 1,
  parameter int          BOUNCE_CYCLES = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] clean_signal,
  output logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] busy
);

  localparam int              CNT_W    = cnt_width(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] toggle_en;

`ifdef BOUNCE_GEN_LFSR_EN
  logic [LFSR_W-1:0] lfsr_state;

  bounce_gen_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .state (lfsr_state)
  );

  for (genvar t = 0; t < WIDTH; t++) begin : g_toggle_en
    assign toggle_en[t] = lfsr_state[t % LFSR_W];
  end
`else
  assign toggle_en = {WIDTH{1'b1}};
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    bounce_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             glitchy_q;
    logic             busy_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        glitchy_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (clean_signal[i] != level_q) begin
              level_q   <= clean_signal[i];
              glitchy_q <= ~glitchy_q;
              cnt_q     <= CNT_LOAD;
              state_q   <= BOUNCE;
              busy_q    <= 1'b1;
            end else begin
              glitchy_q <= level_q;
              busy_q    <= 1'b0;
            end
          end
          BOUNCE: begin
            // A new input change restarts the burst from full length.
            if (clean_signal[i] != level_q) begin
              level_q <= clean_signal[i];
              cnt_q   <= CNT_LOAD;
              busy_q  <= 1'b1;
              if (toggle_en[i]) begin
                glitchy_q <= ~glitchy_q;
              end
            end else if (cnt_q != '0) begin
              cnt_q  <= cnt_q - 1'b1;
              busy_q <= 1'b1;
              if (toggle_en[i]) begin
                glitchy_q <= ~glitchy_q;
              end
            end else begin
              glitchy_q <= level_q;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

    assign glitchy_signal[i] = glitchy_q;
    assign busy[i]           = busy_q;
  end

endmodule

// File: doc/bounce_generator.md
BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 Parameter WIDTH, default 1: number of independent channels.
REQ-002 Parameter BOUNCE_CYCLES, default 10: bounce-burst length in clk cycles; legal range 1..65535.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 clean_signal  input  WIDTH  clean level per channel, synchronous to clk.
REQ-007 glitchy_signal  output  WIDTH  registered bouncy version of clean_signal.
REQ-008 busy  output  WIDTH  per channel, high while that channel is bouncing.

Function
REQ-009 Each channel SHALL run an independent 2-state FSM (IDLE, BOUNCE), with a settled-level register and a bounce down-counter of ceil(log2(BOUNCE_CYCLES)) bits, minimum 1 bit.
REQ-010 IDLE: glitchy_signal[i] SHALL equal level[i] and busy[i] SHALL be 0.
REQ-011 IDLE, edge where clean_signal[i] != level[i]: level <= clean; glitchy <= ~glitchy; cnt <= BOUNCE_CYCLES-1; state -> BOUNCE. The first output change is visible one cycle after the input change.
REQ-012 BOUNCE with cnt != 0: cnt decrements; glitchy toggles if the toggle enable is 1, else holds (see REQ-020/021).
REQ-013 BOUNCE with cnt == 0: glitchy <= level; state -> IDLE; busy falls on that same edge.
REQ-014 busy[i] SHALL be 1 exactly when the state is BOUNCE; busy is a registered state decode with no combinational path from clean_signal.
REQ-015 Retrigger: if clean_signal[i] != level[i] on any BOUNCE edge, the new level is latched, cnt reloads to BOUNCE_CYCLES-1, and glitchy still toggles or holds per REQ-012; the state stays BOUNCE.
REQ-016 After the final input change, glitchy_signal[i] SHALL equal clean_signal[i] permanently from edge BOUNCE_CYCLES onward, counting the detecting edge as edge 0.
REQ-017 BOUNCE_CYCLES == 1: a single toggle on edge 0, then the level is forced on edge 1.
REQ-018 Channels SHALL NOT interact except by sharing the LFSR.

Reset
REQ-019 On a rst edge: glitchy_signal <= 0, level <= 0, busy <= 0, all states <= IDLE, all cnt <= 0, LFSR <= seed. Reset overrides any simultaneous input change, and reset mid-burst aborts the burst with no residual toggles.

Configuration
REQ-020 BOUNCE_GEN_LFSR_EN defined: one shared 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every non-reset cycle. The toggle enable for channel i is lfsr[i mod 16].
REQ-021 BOUNCE_GEN_LFSR_EN undefined: the LFSR is not instantiated, the toggle enable is constant 1, and glitchy toggles on every BOUNCE edge with cnt != 0 (deterministic square wave).

Structure
REQ-022 Package bounce_gen_pkg SHALL hold the state encodings (IDLE=1'b0, BOUNCE=1'b1), the LFSR width (16), the tap mask 16'hB400 and the zero-seed substitute value.
REQ-023 The LFSR SHALL be a sub-module bounce_gen_lfsr (clk, rst, seed, state output), instantiated only under BOUNCE_GEN_LFSR_EN.
REQ-024 Per-channel logic SHALL be a generate loop in bounce_generator; no further sub-modules.

Verification
REQ-025 Macro off, WIDTH=2, BOUNCE_CYCLES=10: clean[0] 0->1 held -> glitchy[0] after edges 0..10 is 1,0,1,0,1,0,1,0,1,0,1, then stays 1; busy[0] high after edges 0..9; glitchy[1] stays 0.
REQ-026 Macro off: clean[0] 1->0 at edge 4 of a burst -> cnt reloads to 9, level 0, and glitchy[0]==0 and busy[0]==0 from 10 edges after the retrigger edge onward.
REQ-027 rst asserted on edge 5 of a burst -> on that edge glitchy=0, busy=0; with clean held at 0 the output stays 0 for 50 cycles; with clean=1 a fresh burst starts on the first edge after rst deasserts.
REQ-028 BOUNCE_CYCLES=1: clean 0->1 -> glitchy=1 after edge 0, busy=1 for exactly one cycle, glitchy remains 1.
REQ-029 Macro on, LFSR_SEED=16'hACE1: run 1000 random clean changes and compare glitchy against a bit-exact reference model of the LFSR; check that glitchy==clean holds at BOUNCE_CYCLES edges after each final change.
REQ-030 Macro on, LFSR_SEED=0: LFSR register equals 16'h0001 after reset and never reaches 0 over 70000 cycles.
